shift_reg_universal: RTL and testbench
======================================

Name: shift_reg_universal

Overview:
Parametrised universal shift register, the successor to the fixed 8-bit serial-in left shifter. Supports hold, logical and arithmetic shifts, rotates, parallel load and clear. Carries a registered serial output, a shift counter and a word-complete pulse, so it can serve as a serial-to-parallel or parallel-to-serial converter in the serial I/O datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range 2 to 64.
CNT_W, derived localparam = clog2(WIDTH+1), width of the shift counter (not overridable).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-low.
en  input  1  operation enable; when low, all state holds.
mode  input  3  operation select; encoding in Behaviour.
sin  input  1  serial input bit, used by SHL and SHR.
d  input  WIDTH  parallel load data.
q  output  WIDTH  register contents (registered).
sout  output  1  bit leaving the register on the last shift or rotate (registered).
cnt  output  CNT_W  shifts performed since the last load, clear or word completion (registered).
word_done  output  1  one-cycle pulse: WIDTH shifts completed (registered).

Behaviour:
- Reset: rst low at a rising clk edge forces q=0, sout=0, cnt=0, word_done=0. Reset has priority over en and mode. Reset mid-word discards the partial word; no word_done is produced.
- en low: q, sout and cnt hold; word_done=0.
- en high, mode encoding, with N = WIDTH:
  - 0 HOLD: q, sout and cnt unchanged.
  - 1 SHL: q <= {q[N-2:0], sin}; sout <= q[N-1].
  - 2 SHR: q <= {sin, q[N-1:1]}; sout <= q[0].
  - 3 ROL: q <= {q[N-2:0], q[N-1]}; sout <= q[N-1].
  - 4 ROR: q <= {q[0], q[N-1:1]}; sout <= q[0].
  - 5 ASR: q <= {q[N-1], q[N-1:1]}; sout <= q[0].
  - 6 LOAD: q <= d; sout <= 0; cnt <= 0.
  - 7 CLEAR: q <= 0; sout <= 0; cnt <= 0.
- Shift ops are modes 1 to 5. Each shift op:
  - increments cnt when cnt < N-1;
  - when cnt == N-1, sets cnt <= 0 and word_done <= 1 in the same edge as the q update.
- word_done is 0 on every edge that is not a completing shift. It never stays high for two consecutive cycles unless two words complete back-to-back, which is impossible for N >= 2.
- Latency: one clock from the mode/sin/d sample to the q, sout, cnt and word_done update. No combinational path from inputs to outputs.
- A LOAD or CLEAR mid-word aborts the count; the next word needs a full N shifts.
- HOLD with en high, and en low, both leave cnt mid-count intact. A word may be shifted in non-contiguous cycles.
- Modes are fully decoded; no illegal encodings exist.

Decomposition:
- Shared header shift_reg_defs.vh holds:
  - the mode encodings MODE_HOLD through MODE_CLEAR (3-bit constants);
  - the clog2 function used for CNT_W.
  Other serial blocks reuse these.
- One sub-module is natural: shift_bit_cnt.
  - Parametrised by WIDTH.
  - Inputs: clk, rst, inc, clr.
  - Outputs: cnt, done pulse.
  - Owns the wrap and word_done logic.
  - The top contains the mode mux and the q/sout registers.

Test Plan:
All cases use WIDTH=8.
1. Drive rst=0 for 2 cycles with en=1, mode=LOAD, d=8'hFF -> q=8'h00, sout=0, cnt=0, word_done=0 after each edge.
2. SHL of sin bits 1,0,1,0,0,1,0,1 over 8 consecutive cycles -> q=8'hA5, cnt 1..7 then 0; word_done high only after the 8th edge.
3. LOAD 8'h81, then ROL -> q=8'h03, sout=1. Then ROR twice -> q=8'h81 after the first ROR and 8'hC0 after the second, sout=1 both times.
4. LOAD 8'h80, then ASR x3 -> q=8'hC0, 8'hE0, 8'hF0, sout=0 each. Then SHR with sin=0 -> q=8'h78, sout=0.
5. Run 5 SHL, 2 cycles of en=0, 3 SHL -> cnt holds at 5 while en=0; word_done fires on the 8th shift. Repeat with LOAD after 5 shifts -> cnt=0, and word_done comes only after 8 further shifts.
6. After 6 SHR, assert rst low for 1 cycle -> q=0, cnt=0, no word_done. The following 8 shifts produce exactly one word_done.

Source files
------------

// File: rtl/shift_reg_universal_pkg.sv
// Shared definitions for the serial blocks: mode encodings and the
// ceiling-log2 helper used to size shift counters.
package shift_reg_universal_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_SHL   = 3'd1;
    localparam logic [2:0] MODE_SHR   = 3'd2;
    localparam logic [2:0] MODE_ROL   = 3'd3;
    localparam logic [2:0] MODE_ROR   = 3'd4;
    localparam logic [2:0] MODE_ASR   = 3'd5;
    localparam logic [2:0] MODE_LOAD  = 3'd6;
    localparam logic [2:0] MODE_CLEAR = 3'd7;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_bit_cnt.sv
// Shift counter: counts shifts up to WIDTH, wraps to zero and pulses done
// on the completing shift. clr aborts a partial word.
module shift_bit_cnt
    import shift_reg_universal_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             done_d, done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register with registered serial output, shift counter
// and word-complete pulse for serial/parallel conversion.
module shift_reg_universal
    import shift_reg_universal_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CNT_W-1:0] cnt,
    output logic             word_done
);

    logic [WIDTH-1:0] q_d, q_q;
    logic             sout_d, sout_q;
    logic             shift;
    logic             cnt_clr;

    always_comb begin
        q_d     = q_q;
        sout_d  = sout_q;
        shift   = 1'b0;
        cnt_clr = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sin};
                    sout_d = q_q[WIDTH-1];
                    shift  = 1'b1;
                end
                MODE_SHR: begin
                    q_d    = {sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                    shift  = 1'b1;
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                    shift  = 1'b1;
                end
                MODE_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                    shift  = 1'b1;
                end
                MODE_ASR: begin
                    q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                    shift  = 1'b1;
                end
                MODE_LOAD: begin
                    q_d     = d;
                    sout_d  = 1'b0;
                    cnt_clr = 1'b1;
                end
                MODE_CLEAR: begin
                    q_d     = '0;
                    sout_d  = 1'b0;
                    cnt_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q    <= '0;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    shift_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (shift),
        .clr  (cnt_clr),
        .cnt  (cnt),
        .done (word_done)
    );

    assign q    = q_q;
    assign sout = sout_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal (WIDTH=8): directed scenarios plus random
// traffic, all checked against an arithmetic reference model.
module tb_shift_reg_universal;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic         sin;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         sout;
    logic [3:0]   cnt;
    logic         word_done;

    int n_cmp;
    int n_mis;
    int done_seen;

    int m_q, m_sout, m_cnt, m_done;

    shift_reg_universal #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin       (sin),
        .d         (d),
        .q         (q),
        .sout      (sout),
        .cnt       (cnt),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: register treated as an integer 0..255, shifts as *2, /2, %.
    task automatic model(input int r, input int e, input int md, input int s, input int dv);
        m_done = 0;
        if (r == 0) begin
            m_q = 0; m_sout = 0; m_cnt = 0;
        end else if (e != 0) begin
            case (md)
                1: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + s; end
                2: begin m_sout = m_q % 2;   m_q = m_q / 2 + s * 128; end
                3: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
                4: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128; end
                5: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q / 128) * 128; end
                6: begin m_q = dv; m_sout = 0; m_cnt = 0; end
                7: begin m_q = 0;  m_sout = 0; m_cnt = 0; end
                default: ;
            endcase
            if (md >= 1 && md <= 5) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_cnt  = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic step(input int r, input int e, input int md, input int s, input int dv);
        rst  = 1'(r);
        en   = 1'(e);
        mode = 3'(md);
        sin  = 1'(s);
        d    = W'(dv);
        @(posedge clk);
        #1;
        model(r, e, md, s, dv);
        if (word_done === 1'b1) done_seen++;
        chk("q", 64'(q), 64'(m_q));
        chk("sout", 64'(sout), 64'(m_sout));
        chk("cnt", 64'(cnt), 64'(m_cnt));
        chk("word_done", 64'(word_done), 64'(m_done));
    endtask

    int base;
    int bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        n_cmp = 0; n_mis = 0; done_seen = 0;
        m_q = 0; m_sout = 0; m_cnt = 0; m_done = 0;
        rst = 1'b0; en = 1'b0; mode = 3'd0; sin = 1'b0; d = '0;

        // reset beats an active LOAD
        step(0, 1, 6, 0, 8'hFF);
        chk("t1_q", 64'(q), 64'h00);
        step(0, 1, 6, 0, 8'hFF);
        chk("t1_cnt", 64'(cnt), 64'h0);

        base = done_seen;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, bits[i], 0);
            chk("t2_cnt", 64'(cnt), 64'((i + 1) % 8));
        end
        chk("t2_q", 64'(q), 64'hA5);
        chk("t2_done", 64'(done_seen - base), 64'd1);

        step(1, 1, 6, 0, 8'h81);
        step(1, 1, 3, 0, 0);
        chk("t3_rol", 64'(q), 64'h03);
        step(1, 1, 4, 0, 0);
        chk("t3_ror1", 64'(q), 64'h81);
        step(1, 1, 4, 0, 0);
        chk("t3_ror2", 64'(q), 64'hC0);
        chk("t3_sout", 64'(sout), 64'd1);

        step(1, 1, 6, 0, 8'h80);
        step(1, 1, 5, 0, 0);
        chk("t4_asr1", 64'(q), 64'hC0);
        step(1, 1, 5, 0, 0);
        step(1, 1, 5, 0, 0);
        chk("t4_asr3", 64'(q), 64'hF0);
        step(1, 1, 2, 0, 0);
        chk("t4_shr", 64'(q), 64'h78);

        // gapped word
        step(1, 1, 7, 0, 0);
        base = done_seen;
        for (int i = 0; i < 5; i++) step(1, 1, 1, i % 2, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 6, 1, 8'h55);
        chk("t5_hold_cnt", 64'(cnt), 64'd5);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
        chk("t5_gap_done", 64'(done_seen - base), 64'd1);

        // LOAD mid-word restarts the count
        base = done_seen;
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 6, 0, 8'h3C);
        chk("t5_load_cnt", 64'(cnt), 64'd0);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0);
        chk("t5_no_early_done", 64'(done_seen - base), 64'd0);
        step(1, 1, 1, 0, 0);
        chk("t5_load_done", 64'(done_seen - base), 64'd1);

        // reset mid-word discards it
        base = done_seen;
        for (int i = 0; i < 6; i++) step(1, 1, 2, 1, 0);
        step(0, 1, 2, 1, 0);
        chk("t6_rst_q", 64'(q), 64'h00);
        for (int i = 0; i < 8; i++) step(1, 1, 2, 1, 0);
        chk("t6_done", 64'(done_seen - base), 64'd1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0) ? 0 : 1,
                 ($urandom_range(0, 4) == 0) ? 0 : 1,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
